// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the future receiver):
// frame state encoding, parity selector codes and the fallback word length.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [3:0] DEFAULT_WORDLEN = 4'd8;

  // Word lengths outside 5..max_len fall back to 8 data bits.
  function automatic logic [3:0] eff_wordlen(input logic [3:0] wl, input int max_len);
    return ((wl >= 4'd5) && (int'(wl) <= max_len)) ? wl : DEFAULT_WORDLEN;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop, occupancy count and empty/full flags.
// Pointers wrap modulo DEPTH (a power of two); push is ignored when full and
// pop is ignored when empty, so the count can never leave 0..DEPTH.
// 'clear' synchronously empties the FIFO (stored words become unreachable).
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next storage, pointer and occupancy values; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers with asynchronous reset to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: valid/ready write port into a FIFO, followed by a frame
// serialiser (start, 5..MAX_WORD_LEN data bits LSB first, optional even/odd
// parity, 1 or 2 stop bits). Bit timing counts external baud_tick enables,
// OVERSAMPLE per bit, or half that with u2x. Frame config is latched at pop.
// Optional: define UART_TX_CTS_EN to add an active-low cts_n flow-control
// input that gates frame starts through a 2-flop synchroniser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int MAX_WORD_LEN = 9,
  parameter int FIFO_DEPTH   = 8,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          txen,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [MAX_WORD_LEN-1:0]       wr_data,
  input  logic [3:0]                    wordlen,
  input  logic [1:0]                    parity,
  input  logic                          stopbits,
  input  logic                          u2x,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

  tx_state_e               state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [3:0]              bit_q, bit_d;
  logic [MAX_WORD_LEN-1:0] shift_q, shift_d;
  logic [3:0]              wl_q, wl_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    stop2_q, stop2_d;
  logic                    u2x_q, u2x_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [MAX_WORD_LEN-1:0] fifo_rd_data;
  logic [MAX_WORD_LEN-1:0] mask;
  logic [3:0]              cur_wl;
  logic                    pop, push, can_start, start_frame, last_tick, cts_ok;

  assign wr_ready = txen && !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

  uart_sync_fifo #(
    .WIDTH (MAX_WORD_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (!txen),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q, cts_sync_d;

  // Shift cts_n into the synchroniser; frames may start only once it reads low.
  always_comb begin
    cts_sync_d = {cts_sync_q[0], cts_n};
  end

  // Synchroniser flops reset to "not clear to send".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= cts_sync_d;
    end
  end

  assign cts_ok = !cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign cur_wl    = eff_wordlen(wordlen, MAX_WORD_LEN);
  assign can_start = !fifo_empty && cts_ok;
  assign last_tick = u2x_q ? (tick_q == TICK_HALF_LAST) : (tick_q == TICK_FULL_LAST);
  assign pop       = start_frame;

  // Keep only the data bits that the current word length will send.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_WORD_LEN; i++) begin
      mask[i] = (i < int'(cur_wl));
    end
  end

  // Frame sequencer: tick/bit counting, tx level, and frame start/stop.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    wl_d        = wl_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    u2x_d       = u2x_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    start_frame = 1'b0;

    if (!txen) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
    end else begin
      if (state_q != ST_IDLE && baud_tick) begin
        tick_d = last_tick ? '0 : tick_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (baud_tick && can_start) begin
            start_frame = 1'b1;
          end
        end
        ST_START: begin
          if (baud_tick && last_tick) begin
            state_d = ST_DATA;
            bit_d   = '0;
            tx_d    = shift_q[0];
          end
        end
        ST_DATA: begin
          if (baud_tick && last_tick) begin
            if (bit_q == wl_q - 4'd1) begin
              bit_d = '0;
              if (par_en_q) begin
                state_d = ST_PARITY;
                tx_d    = par_bit_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (baud_tick && last_tick) begin
            state_d = ST_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_tick && last_tick) begin
            if (stop2_q && bit_q == 4'd0) begin
              bit_d = 4'd1;
            end else begin
              done_d = 1'b1;
              if (can_start) begin
                start_frame = 1'b1;
              end else begin
                state_d = ST_IDLE;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase

      if (start_frame) begin
        state_d   = ST_START;
        tick_d    = '0;
        bit_d     = '0;
        tx_d      = 1'b0;
        busy_d    = 1'b1;
        wl_d      = cur_wl;
        shift_d   = fifo_rd_data & mask;
        par_en_d  = (parity == PAR_EVEN) || (parity == PAR_ODD);
        par_bit_d = (^(fifo_rd_data & mask)) ^ (parity == PAR_ODD);
        stop2_d   = stopbits;
        u2x_d     = u2x;
      end
    end
  end

  // Sequencer registers; tx returns high immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wl_q      <= DEFAULT_WORDLEN;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      u2x_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wl_q      <= wl_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      u2x_q     <= u2x_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: frame shapes with hand-computed bit
// patterns, FIFO fill/back-to-back draining, txen flush, async reset, and
// (when UART_TX_CTS_EN is defined) clear-to-send gating.
module tb_uart_tx_fifo;

  localparam int MAX_WORD_LEN = 9;
  localparam int FIFO_DEPTH   = 8;
  localparam int OVERSAMPLE   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       txen;
  logic       wr_valid;
  logic       wr_ready;
  logic [8:0] wr_data;
  logic [3:0] wordlen;
  logic [1:0] parity;
  logic       stopbits;
  logic       u2x;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [3:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  int checkCount = 0;
  int failCount  = 0;

  logic [8:0] words [9];
  logic       seenDone;

  uart_tx_fifo #(
    .MAX_WORD_LEN (MAX_WORD_LEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .OVERSAMPLE   (OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .txen       (txen),
`ifdef UART_TX_CTS_EN
    .cts_n      (cts_n),
`endif
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wordlen    (wordlen),
    .parity     (parity),
    .stopbits   (stopbits),
    .u2x        (u2x),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present one word for a single cycle; called and returns at a negedge.
  task automatic applyStimulus(input logic [8:0] data);
    wr_valid = 1'b1;
    wr_data  = data;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Wait (bounded) for tx to go low, i.e. the first cycle of a start bit.
  task automatic waitTxLow(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_start"}, 32'(tx), 32'd0);
  endtask

  // Follow one frame with baud_tick held high; bits[0] is the start bit.
  // Checks the first and last cycle of every bit, the tx_done pulse, and
  // whether the next frame follows with no idle gap.
  task automatic checkFrame(input string tag, input logic [15:0] bits, input int nbits,
                            input int n, input bit expectNext, input bit poke);
    int total;
    total = nbits * n;
    waitTxLow(tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    for (int c = 0; c <= total; c++) begin
      if (c < total) begin
        if ((c % n == 0) || (c % n == n - 1)) begin
          checkOutput($sformatf("%s_bit%0d_c%0d", tag, c / n, c), 32'(tx), 32'(bits[c / n]));
        end
        if (c == total - 1) begin
          checkOutput({tag, "_done_early"}, 32'(tx_done), 32'd0);
        end
        if (poke && c == 20) begin
          wordlen  = 4'd5;
          parity   = 2'd1;
          stopbits = 1'b1;
          u2x      = 1'b1;
        end
        @(negedge clk);
      end else begin
        checkOutput({tag, "_done"}, 32'(tx_done), 32'd1);
        checkOutput({tag, "_tx_after"}, 32'(tx), expectNext ? 32'd0 : 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy), expectNext ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    words[0] = 9'h000; words[1] = 9'h0FF; words[2] = 9'h0A5;
    words[3] = 9'h03C; words[4] = 9'h001; words[5] = 9'h080;
    words[6] = 9'h05A; words[7] = 9'h0C3; words[8] = 9'h077;

    rst       = 1'b1;
    baud_tick = 1'b0;
    txen      = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wordlen   = 4'd8;
    parity    = 2'd0;
    stopbits  = 1'b0;
    u2x       = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n     = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);
    checkOutput("rst_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
    checkOutput("rst_full", 32'(fifo_full), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, 0x55: start one cycle after the pop, 10 bits of 16 ticks
    applyStimulus(9'h055);
    checkOutput("f55_count1", 32'(fifo_count), 32'd1);
    checkOutput("f55_idle_tx", 32'(tx), 32'd1);
    baud_tick = 1'b1;
    @(negedge clk);
    checkOutput("f55_first_tx", 32'(tx), 32'd0);
    checkOutput("f55_count0", 32'(fifo_count), 32'd0);
    checkFrame("f55", 16'h02AA, 10, 16, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("f55_done_pulse", 32'(tx_done), 32'd0);

    // 0x41, 7 data bits, even parity -> parity 0
    wordlen = 4'd7;
    parity  = 2'd1;
    applyStimulus(9'h041);
    checkFrame("even", 16'h0282, 10, 16, 1'b0, 1'b0);

    // 0x41, 7 data bits, odd parity, two stop bits -> 11 bits, 176 ticks
    parity   = 2'd2;
    stopbits = 1'b1;
    applyStimulus(9'h041);
    checkFrame("odd", 16'h0782, 11, 16, 1'b0, 1'b0);

    // u2x, 5N1, 0x1F -> 8 ticks per bit, 56 ticks
    wordlen  = 4'd5;
    parity   = 2'd0;
    stopbits = 1'b0;
    u2x      = 1'b1;
    applyStimulus(9'h01F);
    checkFrame("u2x", 16'h007E, 7, 8, 1'b0, 1'b0);

    // wordlen 3 falls back to 8, bit 8 ignored, config changes mid-frame ignored
    wordlen = 4'd3;
    u2x     = 1'b0;
    applyStimulus(9'h1A3);
    checkFrame("wl3", 16'h0346, 10, 16, 1'b0, 1'b1);
    wordlen  = 4'd8;
    parity   = 2'd0;
    stopbits = 1'b0;
    u2x      = 1'b0;

    // Fill the FIFO with baud_tick held off; the ninth word is refused
    baud_tick = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(words[i]);
    end
    checkOutput("full_count", 32'(fifo_count), 32'd8);
    checkOutput("full_flag", 32'(fifo_full), 32'd1);
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("full_empty", 32'(fifo_empty), 32'd0);
    baud_tick = 1'b1;
    @(negedge clk);
    checkOutput("drain_count7", 32'(fifo_count), 32'd7);
    checkOutput("drain_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkFrame($sformatf("b2b%0d", i), {6'b0, 1'b1, words[i][7:0], 1'b0}, 10, 16, (i < 7), 1'b0);
    end
    checkOutput("drain_count0", 32'(fifo_count), 32'd0);
    checkOutput("drain_empty", 32'(fifo_empty), 32'd1);
    repeat (50) @(negedge clk);
    checkOutput("no_ninth_tx", 32'(tx), 32'd1);
    checkOutput("no_ninth_busy", 32'(busy), 32'd0);

    // txen dropped in data bit 3 with words queued
    baud_tick = 1'b0;
    applyStimulus(9'h000);
    applyStimulus(9'h000);
    applyStimulus(9'h000);
    checkOutput("txen_count3", 32'(fifo_count), 32'd3);
    baud_tick = 1'b1;
    waitTxLow("txen");
    repeat (69) @(negedge clk);
    checkOutput("txen_pre_tx", 32'(tx), 32'd0);
    checkOutput("txen_pre_busy", 32'(busy), 32'd1);
    txen = 1'b0;
    @(negedge clk);
    checkOutput("txen_tx", 32'(tx), 32'd1);
    checkOutput("txen_count", 32'(fifo_count), 32'd0);
    checkOutput("txen_busy", 32'(busy), 32'd0);
    checkOutput("txen_empty", 32'(fifo_empty), 32'd1);
    checkOutput("txen_wr_ready", 32'(wr_ready), 32'd0);
    seenDone = tx_done;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_done) seenDone = 1'b1;
    end
    checkOutput("txen_no_done", 32'(seenDone), 32'd0);
    txen = 1'b1;
    @(negedge clk);
    checkOutput("txen_back_ready", 32'(wr_ready), 32'd1);
    checkOutput("txen_back_tx", 32'(tx), 32'd1);

    // Asynchronous reset mid-frame
    applyStimulus(9'h000);
    waitTxLow("rstmid");
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_tx", 32'(tx), 32'd1);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_after_tx", 32'(tx), 32'd1);

`ifdef UART_TX_CTS_EN
    // Clear-to-send gating
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(9'h055);
    repeat (40) @(negedge clk);
    checkOutput("cts_hold_tx", 32'(tx), 32'd1);
    checkOutput("cts_hold_busy", 32'(busy), 32'd0);
    checkOutput("cts_hold_count", 32'(fifo_count), 32'd1);
    cts_n = 1'b0;
    @(negedge clk);
    checkOutput("cts_tick1", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("cts_tick2", 32'(tx), 32'd1);
    @(negedge clk);
    checkOutput("cts_tick3", 32'(tx), 32'd0);
    cts_n = 1'b1;
    checkFrame("cts", 16'h02AA, 10, 16, 1'b0, 1'b0);
    applyStimulus(9'h055);
    repeat (60) @(negedge clk);
    checkOutput("cts_wait_tx", 32'(tx), 32'd1);
    checkOutput("cts_wait_count", 32'(fifo_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
